// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA timing generators.
//   line_cfg_t : per-line segment lengths (visible, front, sync, back) + sync polarity
//   seg_e      : line segments, with LINE_END as the "no further segment" marker
//   next_seg   : next non-zero segment after the current one
//   seg_len    : length field of a given segment
//   cfg_valid  : config is usable (visible != 0 and total length >= 2)
package vga_pkg;

   localparam int LINE_CNT_W = 12;

   typedef struct packed {
      logic [LINE_CNT_W-1:0] visible;
      logic [LINE_CNT_W-1:0] front;
      logic [LINE_CNT_W-1:0] sync;
      logic [LINE_CNT_W-1:0] back;
      logic                  sync_pol;
   } line_cfg_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ACT      = 3'd1,
      FRP      = 3'd2,
      SYN      = 3'd3,
      BCP      = 3'd4,
      LINE_END = 3'd5
   } seg_e;

   // Segments are visited in enum order; any zero-length segment is skipped,
   // so the search starts at the segment right after cur.
   function automatic seg_e next_seg(seg_e cur, line_cfg_t c);
      seg_e nxt;
      nxt = LINE_END;
      if (cur == IDLE && c.visible != '0)
         nxt = ACT;
      else if (cur inside {IDLE, ACT} && c.front != '0)
         nxt = FRP;
      else if (cur inside {IDLE, ACT, FRP} && c.sync != '0)
         nxt = SYN;
      else if (cur inside {IDLE, ACT, FRP, SYN} && c.back != '0)
         nxt = BCP;
      return nxt;
   endfunction

   function automatic logic [LINE_CNT_W-1:0] seg_len(seg_e s, line_cfg_t c);
      logic [LINE_CNT_W-1:0] len;
      case (s)
         ACT:     len = c.visible;
         FRP:     len = c.front;
         SYN:     len = c.sync;
         BCP:     len = c.back;
         default: len = '0;
      endcase
      return len;
   endfunction

   // Two extra bits so four full-scale fields cannot wrap the sum.
   function automatic logic cfg_valid(line_cfg_t c);
      logic [LINE_CNT_W+1:0] total;
      total = {2'b00, c.visible} + {2'b00, c.front} + {2'b00, c.sync} + {2'b00, c.back};
      return (c.visible != '0) && (total >= (LINE_CNT_W+2)'(2));
   endfunction

endpackage

// File: rtl/vga_line_gen.sv
// Line timing generator: steps ACT -> FRP -> SYN -> BCP once per inc_i strobe.
// Ports:
//   clk_i, rst_i (sync, active-high), inc_i (advance strobe), en_i (run request)
//   cfg_i      : line_cfg_t, shadowed at every line start
//   de_o       : visible area
//   hs_o       : sync with polarity applied
//   pos_o      : index within the visible area, 0 outside it
//   sol_o      : first visible strobe period
//   eol_o      : last strobe period of the line
//   nol_o      : eol_o & inc_i, the line ends on this clock
//   busy_o     : not idle
//   cfg_err_o  : last loaded config was unusable (sticky)
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | stopped; waits for en_i on a strobe
// ACT      | visible pixels, pos_q counts up
// FRP      | front porch
// SYN      | sync pulse
// BCP      | back porch
module vga_line_gen
   import vga_pkg::*;
#(
   parameter int CNT_W           = LINE_CNT_W,
   parameter bit LAST_SEG_IS_EOL = 1'b1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             en_i,
   input  line_cfg_t        cfg_i,
   output logic             de_o,
   output logic             hs_o,
   output logic [CNT_W-1:0] pos_o,
   output logic             sol_o,
   output logic             eol_o,
   output logic             nol_o,
   output logic             busy_o,
   output logic             cfg_err_o
);

   seg_e             state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] pos_q, pos_d;
   line_cfg_t        cfg_q, cfg_d;
   logic             cfg_err_q, cfg_err_d;

   seg_e nxt_seg;
   logic seg_done;
   logic line_done;
   logic line_load;

   assign nxt_seg   = next_seg(state_q, cfg_q);
   assign seg_done  = (state_q != IDLE) && (cnt_q == '0);
   assign line_done = seg_done && (nxt_seg == LINE_END);
   // A new line is set up either from IDLE on a run request or at the end of
   // the current line; both paths reload the shadow config.
   assign line_load = (state_q == IDLE) ? en_i : line_done;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pos_d     = pos_q;
      cfg_d     = cfg_q;
      cfg_err_d = cfg_err_q;

      if (inc_i) begin
         if (line_load) begin
            cfg_d   = cfg_i;
            pos_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
            if (en_i) begin
               if (cfg_valid(cfg_i)) begin
                  state_d   = ACT;
                  cnt_d     = CNT_W'(cfg_i.visible - LINE_CNT_W'(1));
                  cfg_err_d = 1'b0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end else if (state_q != IDLE) begin
            if (seg_done) begin
               state_d = nxt_seg;
               cnt_d   = CNT_W'(seg_len(nxt_seg, cfg_q) - LINE_CNT_W'(1));
               pos_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (state_q == ACT)
                  pos_d = pos_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pos_q     <= '0;
         cfg_q     <= cfg_i;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pos_q     <= pos_d;
         cfg_q     <= cfg_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign de_o      = (state_q == ACT);
   assign hs_o      = (state_q == SYN) ? cfg_q.sync_pol : ~cfg_q.sync_pol;
   assign pos_o     = pos_q;
   assign sol_o     = (state_q == ACT) && (pos_q == '0);
   // Only the "last non-zero segment" flavour exists; the parameter is kept so
   // horizontal and vertical instances share a parameter list.
   assign eol_o     = line_done && LAST_SEG_IS_EOL;
   assign nol_o     = eol_o && inc_i;
   assign busy_o    = (state_q != IDLE);
   assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_vga_line_gen.sv
module tb_vga_line_gen;
   import vga_pkg::*;

   localparam int W = LINE_CNT_W;
   localparam int S_ACT = 1, S_FRP = 2, S_SYN = 3, S_BCP = 4;

   logic         clk = 1'b0;
   logic         rst, inc, en;
   line_cfg_t    cfg;
   logic         de_o, hs_o, sol_o, eol_o, nol_o, busy_o, cfg_err_o;
   logic [W-1:0] pos_o;

   vga_line_gen #(.CNT_W(W), .LAST_SEG_IS_EOL(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .inc_i(inc), .en_i(en), .cfg_i(cfg),
      .de_o(de_o), .hs_o(hs_o), .pos_o(pos_o), .sol_o(sol_o), .eol_o(eol_o),
      .nol_o(nol_o), .busy_o(busy_o), .cfg_err_o(cfg_err_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: a line is a list of strobes; the head is the current one.
   typedef struct { int seg; int pos; } strobe_t;
   strobe_t   m_q[$];
   bit        m_idle;
   line_cfg_t m_cfg;
   bit        m_err;

   // Per-line statistics gathered from DUT outputs on strobe clocks.
   int nol_q[$];
   int de_q[$];
   int hsh_q[$];
   int line_de, line_hsh, run_idx;

   function automatic line_cfg_t mk(int v, int f, int s, int b, bit p);
      line_cfg_t c;
      c.visible = W'(v); c.front = W'(f); c.sync = W'(s); c.back = W'(b); c.sync_pol = p;
      return c;
   endfunction

   function automatic bit m_valid(line_cfg_t c);
      int t;
      t = int'(c.visible) + int'(c.front) + int'(c.sync) + int'(c.back);
      return (c.visible != 0) && (t >= 2);
   endfunction

   task automatic m_build(line_cfg_t c);
      strobe_t s;
      m_q.delete();
      for (int i = 0; i < int'(c.visible); i++) begin s.seg = S_ACT; s.pos = i; m_q.push_back(s); end
      for (int i = 0; i < int'(c.front); i++)   begin s.seg = S_FRP; s.pos = 0; m_q.push_back(s); end
      for (int i = 0; i < int'(c.sync); i++)    begin s.seg = S_SYN; s.pos = 0; m_q.push_back(s); end
      for (int i = 0; i < int'(c.back); i++)    begin s.seg = S_BCP; s.pos = 0; m_q.push_back(s); end
   endtask

   task automatic m_start();
      m_cfg = cfg;
      if (!en) begin
         m_idle = 1'b1;
      end else if (m_valid(cfg)) begin
         m_err = 1'b0; m_idle = 1'b0; m_build(cfg);
      end else begin
         m_err = 1'b1; m_idle = 1'b1;
      end
   endtask

   task automatic m_update();
      if (rst) begin
         m_idle = 1'b1; m_q.delete(); m_cfg = cfg; m_err = 1'b0;
      end else if (inc) begin
         if (m_idle) begin
            if (en) m_start();
         end else begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_start();
         end
      end
   endtask

   function automatic logic [18:0] m_expect();
      logic de, hs, sol, eol, nol;
      int   p;
      if (m_idle)
         return {1'b0, ~m_cfg.sync_pol, 1'b0, 1'b0, 1'b0, 1'b0, m_err, W'(0)};
      de  = (m_q[0].seg == S_ACT);
      p   = de ? m_q[0].pos : 0;
      hs  = (m_q[0].seg == S_SYN) ? m_cfg.sync_pol : ~m_cfg.sync_pol;
      sol = de && (p == 0);
      eol = (m_q.size() == 1);
      nol = eol && inc;
      return {de, hs, sol, eol, nol, 1'b1, m_err, W'(p)};
   endfunction

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clear_stats();
      nol_q.delete(); de_q.delete(); hsh_q.delete();
      line_de = 0; line_hsh = 0; run_idx = 0;
   endtask

   task automatic tick();
      logic [18:0] act, exp;
      @(negedge clk);
      act = {de_o, hs_o, sol_o, eol_o, nol_o, busy_o, cfg_err_o, pos_o};
      exp = m_expect();
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL cycle %0d: got %h want %h (de,hs,sol,eol,nol,busy,err,pos)", cyc, act, exp);
      end
      if (inc) begin
         line_de  += int'(de_o);
         line_hsh += int'(hs_o);
         if (nol_o) begin
            nol_q.push_back(run_idx); de_q.push_back(line_de); hsh_q.push_back(line_hsh);
            line_de = 0; line_hsh = 0;
         end
      end
      @(posedge clk);
      m_update();
      #1;
      cyc++;
      run_idx++;
   endtask

   task automatic run(int n, int per);
      for (int i = 0; i < n; i++) begin
         inc = ((i % per) == 0);
         tick();
      end
   endtask

   task automatic do_reset(line_cfg_t c);
      cfg = c; rst = 1'b1; inc = 1'b0; en = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   typedef struct { int v; int f; int s; int b; bit exp_err; bit exp_busy; } vec_t;
   vec_t vecs[10];

   initial begin
      vecs[0] = '{4, 2, 3, 1, 1'b0, 1'b1};
      vecs[1] = '{0, 2, 3, 1, 1'b1, 1'b0};
      vecs[2] = '{1, 0, 0, 0, 1'b1, 1'b0};
      vecs[3] = '{1, 1, 0, 0, 1'b0, 1'b1};
      vecs[4] = '{2, 0, 0, 0, 1'b0, 1'b1};
      vecs[5] = '{0, 0, 0, 0, 1'b1, 1'b0};
      vecs[6] = '{4095, 4095, 4095, 4095, 1'b0, 1'b1};
      vecs[7] = '{1, 4095, 0, 0, 1'b0, 1'b1};
      vecs[8] = '{1, 0, 0, 1, 1'b0, 1'b1};
      vecs[9] = '{0, 4095, 0, 0, 1'b1, 1'b0};

      // Initial reset, before the model has a defined state.
      cfg = mk(4, 2, 3, 1, 1'b0); rst = 1'b1; inc = 1'b0; en = 1'b0;
      m_idle = 1'b1; m_err = 1'b0; m_cfg = cfg;
      @(posedge clk); m_update(); #1;
      rst = 1'b0;
      clear_stats();

      // Reset state.
      chk("rst_busy", busy_o, 0);
      chk("rst_hs", hs_o, 1);
      chk("rst_pos", pos_o, 0);

      // Config validity table, one strobe from IDLE.
      foreach (vecs[i]) begin
         do_reset(mk(vecs[i].v, vecs[i].f, vecs[i].s, vecs[i].b, 1'b0));
         en = 1'b1; inc = 1'b1;
         tick();
         en = 1'b0; inc = 1'b0;
         chk($sformatf("vec%0d_err", i), cfg_err_o, vecs[i].exp_err);
         chk($sformatf("vec%0d_busy", i), busy_o, vecs[i].exp_busy);
      end

      // 4/2/3/1, strobe every clock.
      do_reset(mk(4, 2, 3, 1, 1'b0));
      en = 1'b1; clear_stats();
      run(45, 1);
      chk("s1_nol_count", nol_q.size(), 4);
      if (nol_q.size() >= 4) begin
         chk("s1_first_nol", nol_q[0], 10);
         chk("s1_period", nol_q[1] - nol_q[0], 10);
         chk("s1_period2", nol_q[3] - nol_q[2], 10);
         chk("s1_de_per_line", de_q[1], 4);
         chk("s1_hs_high_per_line", hsh_q[1], 7);
      end

      // 4/0/3/0: no porches.
      do_reset(mk(4, 0, 3, 0, 1'b0));
      en = 1'b1; clear_stats();
      run(30, 1);
      chk("s2_nol_count", nol_q.size(), 4);
      if (nol_q.size() >= 2) begin
         chk("s2_period", nol_q[1] - nol_q[0], 7);
         chk("s2_de_per_line", de_q[1], 4);
         chk("s2_hs_high_per_line", hsh_q[1], 4);
      end

      // Strobe every third clock.
      do_reset(mk(4, 2, 3, 1, 1'b0));
      en = 1'b1; clear_stats();
      run(95, 3);
      chk("s3_nol_count", nol_q.size(), 3);
      if (nol_q.size() >= 2) begin
         chk("s3_period", nol_q[1] - nol_q[0], 30);
         chk("s3_de_per_line", de_q[1], 4);
      end

      // Config change mid-ACT takes effect on the next line.
      do_reset(mk(4, 2, 3, 1, 1'b0));
      en = 1'b1;
      run(3, 1);
      cfg = mk(6, 2, 3, 1, 1'b1);
      clear_stats();
      run(30, 1);
      chk("s4_nol_count", nol_q.size(), 2);
      if (nol_q.size() >= 2) begin
         chk("s4_old_line_hs_high", hsh_q[0], 5);
         chk("s4_old_line_de", de_q[0], 2);
         chk("s4_new_line_de", de_q[1], 6);
         chk("s4_new_line_hs_high", hsh_q[1], 3);
         chk("s4_new_period", nol_q[1] - nol_q[0], 12);
      end

      // Drop en during FRP.
      do_reset(mk(4, 2, 3, 1, 1'b0));
      en = 1'b1;
      run(5, 1);
      chk("s5_in_frp_busy", busy_o, 1);
      en = 1'b0; clear_stats();
      run(6, 1);
      chk("s5_nol_count", nol_q.size(), 1);
      chk("s5_busy_after", busy_o, 0);
      run(5, 1);
      chk("s5_stays_idle", busy_o, 0);
      chk("s5_no_more_nol", nol_q.size(), 1);
      en = 1'b1;
      run(1, 1);
      chk("s5_restart_de", de_o, 1);
      chk("s5_restart_sol", sol_o, 1);
      chk("s5_restart_pos", pos_o, 0);

      // Reset in the middle of SYN.
      do_reset(mk(4, 2, 3, 1, 1'b1));
      en = 1'b1;
      run(8, 1);
      chk("s6_in_syn_hs", hs_o, 1);
      rst = 1'b1; inc = 1'b1;
      tick();
      rst = 1'b0;
      chk("s6_de", de_o, 0);
      chk("s6_hs", hs_o, 0);
      chk("s6_pos", pos_o, 0);
      chk("s6_busy", busy_o, 0);
      chk("s6_nol", nol_o, 0);

      // Randomised run against the model.
      do_reset(mk(3, 1, 2, 1, 1'b0));
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0)
            cfg = mk($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         en  = ($urandom_range(0, 7) != 0);
         inc = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
